// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS character codes, character kinds and running-disparity width.
package tmds_pkg;
  typedef enum logic [1:0] {KIND_CTRL, KIND_VIDEO, KIND_GUARD} kind_t;
  localparam int CNT_W = 6;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_CH2 = 10'b1011001100;
  localparam logic [1:0] PRE_CTL_CH1 = 2'b01;
  localparam logic [1:0] PRE_CTL_CH2 = 2'b00;
  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    return c == 2'b00 ? CTRL_00 : c == 2'b01 ? CTRL_01 : c == 2'b10 ? CTRL_10 : CTRL_11;
  endfunction
  function automatic logic [3:0] ones8(input logic [7:0] v);
    ones8 = '0;
    for (int i = 0; i < 8; i++) ones8 = ones8 + {3'b0, v[i]};
  endfunction
endpackage

// File: rtl/tmds_chan_enc.sv
// tmds_chan_enc: one TMDS channel, transition-minimising stage then DC-balancing stage.
module tmds_chan_enc
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  kind_t      kind,
  input  logic [1:0] ctl,
  input  logic [9:0] guard,
  input  logic [7:0] data,
  output logic [9:0] q
);
  logic [3:0] n1_d, n1_q;
  logic use_xnor;
  logic [8:0] qm_d, qm;
  kind_t kind1;
  logic [1:0] ctl1;
  logic [9:0] guard1, q_d;
  logic signed [CNT_W-1:0] cnt, cnt_d, bal;
  assign n1_d = ones8(data);
  assign use_xnor = n1_d > 4'd4 || (n1_d == 4'd4 && !data[0]);
  always_comb begin
    qm_d = {~use_xnor, 7'b0, data[0]};
    for (int i = 1; i < 8; i++) qm_d[i] = qm_d[i-1] ^ data[i] ^ use_xnor;
  end
  // bal = ones - zeros of the stage-1 word
  assign n1_q = ones8(qm[7:0]);
  assign bal = $signed(CNT_W'({n1_q, 1'b0})) - CNT_W'(8);
  always_comb begin
    q_d = kind1 == KIND_GUARD ? guard1 : ctrl_code(ctl1);
    cnt_d = '0;
    if (kind1 == KIND_VIDEO) begin
      if (cnt == 0 || bal == 0) begin
        q_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_d = qm[8] ? cnt + bal : cnt - bal;
      end else if ((cnt > 0 && bal > 0) || (cnt < 0 && bal < 0)) begin
        q_d = {1'b1, qm[8], ~qm[7:0]};
        cnt_d = cnt - bal + (qm[8] ? CNT_W'(2) : '0);
      end else begin
        q_d = {1'b0, qm[8], qm[7:0]};
        cnt_d = cnt + bal - (qm[8] ? '0 : CNT_W'(2));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      qm <= '0;
      kind1 <= KIND_CTRL;
      ctl1 <= '0;
      guard1 <= '0;
      cnt <= '0;
      q <= CTRL_00;
    end else begin
      qm <= qm_d;
      kind1 <= kind;
      ctl1 <= ctl;
      guard1 <= guard;
      cnt <= cnt_d;
      q <= q_d;
    end
  end
endmodule

// File: rtl/tmds_video_encoder.sv
// tmds_video_encoder: multi-channel TMDS encoder with HDMI preamble/guard-band insertion.
module tmds_video_encoder
  import tmds_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int HDMI_MODE    = 1,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic                   pixclk,
  input  logic                   rst,
  input  logic                   vsync,
  input  logic                   hsync,
  input  logic                   active,
  input  logic [NUM_CH*8-1:0]    pix_data,
  output logic [NUM_CH*10-1:0]   tmds,
  output logic                   de_out,
  output logic                   blank_err
);
  localparam int D = HDMI_MODE != 0 ? PREAMBLE_LEN + GUARD_LEN : 0;
  localparam int W = NUM_CH*8 + 3;
  localparam logic [4:0] DL = 5'(D);
  localparam logic [4:0] GL = 5'(GUARD_LEN);
  logic [W-1:0] dl_in, dl_out;
  logic d_vs, d_hs, d_act, active_prev, rise, in_win, pre, de1;
  logic [4:0] win_cnt, blank_run, rem;
  kind_t kind;
  assign dl_in = {vsync, hsync, active, pix_data};
  generate
    if (D == 0) begin : g_bypass
      assign dl_out = dl_in;
    end else begin : g_dl
      logic [W-1:0] line [D];
      always_ff @(posedge pixclk) begin
        line[0] <= rst ? '0 : dl_in;
        for (int i = 1; i < D; i++) line[i] <= rst ? '0 : line[i-1];
      end
      assign dl_out = line[D-1];
    end
  endgenerate
  assign {d_vs, d_hs, d_act} = dl_out[W-1:W-3];
  // the rise is seen at the input while the first window character leaves the delay line
  assign rise = active && !active_prev;
  assign rem = D == 0 ? 5'd0 : rise ? DL : win_cnt;
  assign in_win = rem != 5'd0 && !d_act;
  assign pre = in_win && rem > GL;
  assign kind = d_act ? KIND_VIDEO : in_win && !pre ? KIND_GUARD : KIND_CTRL;
  always_ff @(posedge pixclk) begin
    if (rst) begin
      active_prev <= 1'b0;
      win_cnt <= '0;
      blank_run <= '0;
      blank_err <= 1'b0;
      de1 <= 1'b0;
      de_out <= 1'b0;
    end else begin
      active_prev <= active;
      win_cnt <= rem != 5'd0 ? rem - 5'd1 : 5'd0;
      blank_run <= active ? 5'd0 : blank_run == DL ? blank_run : blank_run + 5'd1;
      blank_err <= blank_err || (rise && blank_run < DL);
      de1 <= d_act;
      de_out <= de1;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tmds_chan_enc u_enc (
      .clk  (pixclk),
      .rst  (rst),
      .kind (kind),
      .ctl  (c == 0 ? {d_vs, d_hs} : pre ? (c == 1 ? PRE_CTL_CH1 : PRE_CTL_CH2) : 2'b00),
      .guard(c == 0 ? GUARD_CH0 : c == 1 ? GUARD_CH1 : GUARD_CH2),
      .data (dl_out[8*c +: 8]),
      .q    (tmds[10*c +: 10])
    );
  end
endmodule

// File: tb/tb_tmds_video_encoder.sv
// tb_tmds_video_encoder: directed checks of DVI, HDMI and 4-channel encoder instances.
module tb_tmds_video_encoder;
  localparam logic [9:0] C00 = 10'h354, C01 = 10'h0AB, C10 = 10'h154, C11 = 10'h2AB;
  localparam logic [9:0] G0 = 10'h2CC, G1 = 10'h133;
  logic pixclk = 1'b0, rst = 1'b1, vsync = 1'b0, hsync = 1'b0, active = 1'b0;
  logic [31:0] pix_data = '0;
  logic [29:0] tmds_d, tmds_h;
  logic [39:0] tmds_q;
  logic de_d, de_h, de_q, err_d, err_h, err_q;
  int checks = 0, errors = 0, n = 0;
  logic [29:0] cap_d [512];
  logic [29:0] cap_h [512];
  logic [39:0] cap_q [512];
  logic cde_d [512];
  logic cde_h [512];
  logic cde_q [512];
  logic cerr_h [512];
  logic in_a [512];
  logic in_v [512];
  logic in_h [512];
  logic [31:0] in_d [512];

  always #5 pixclk = ~pixclk;

  tmds_video_encoder #(.NUM_CH(3), .HDMI_MODE(0)) u_dvi (
    .pixclk(pixclk), .rst(rst), .vsync(vsync), .hsync(hsync), .active(active),
    .pix_data(pix_data[23:0]), .tmds(tmds_d), .de_out(de_d), .blank_err(err_d));
  tmds_video_encoder #(.NUM_CH(3)) u_hdmi (
    .pixclk(pixclk), .rst(rst), .vsync(vsync), .hsync(hsync), .active(active),
    .pix_data(pix_data[23:0]), .tmds(tmds_h), .de_out(de_h), .blank_err(err_h));
  tmds_video_encoder #(.NUM_CH(4)) u_quad (
    .pixclk(pixclk), .rst(rst), .vsync(vsync), .hsync(hsync), .active(active),
    .pix_data(pix_data), .tmds(tmds_q), .de_out(de_q), .blank_err(err_q));

  function automatic logic [9:0] tb_ctrl(input logic v, input logic h);
    case ({v, h})
      2'b00: return C00;
      2'b01: return C01;
      2'b10: return C10;
      default: return C11;
    endcase
  endfunction

  function automatic logic [9:0] ref_enc(input logic [7:0] d, input int cin, output int cout);
    int n1, m1, m0, q8;
    bit xn;
    logic [8:0] qm;
    n1 = $countones(d);
    xn = n1 > 4 || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    q8 = qm[8] ? 1 : 0;
    m1 = $countones(qm[7:0]);
    m0 = 8 - m1;
    if (cin == 0 || m1 == m0) begin
      cout = q8 == 1 ? cin + m1 - m0 : cin + m0 - m1;
      return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    end else if ((cin > 0 && m1 > m0) || (cin < 0 && m0 > m1)) begin
      cout = cin + 2*q8 + m0 - m1;
      return {1'b1, qm[8], ~qm[7:0]};
    end
    cout = cin - 2*(1 - q8) + m1 - m0;
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  task automatic step(input logic v, input logic h, input logic a, input logic [31:0] d);
    vsync = v; hsync = h; active = a; pix_data = d;
    in_v[n] = v; in_h[n] = h; in_a[n] = a; in_d[n] = d;
    @(posedge pixclk);
    #1;
    cap_d[n] = tmds_d; cap_h[n] = tmds_h; cap_q[n] = tmds_q;
    cde_d[n] = de_d; cde_h[n] = de_h; cde_q[n] = de_q; cerr_h[n] = err_h;
    n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      checks++; if (tmds_h !== {3{C00}}) begin errors++; $display("FAIL reset_tmds_h got=%h exp=%h", tmds_h, {3{C00}}); end
      checks++; if (tmds_d !== {3{C00}}) begin errors++; $display("FAIL reset_tmds_d got=%h exp=%h", tmds_d, {3{C00}}); end
      checks++; if (tmds_q !== {4{C00}}) begin errors++; $display("FAIL reset_tmds_q got=%h exp=%h", tmds_q, {4{C00}}); end
      checks++; if ({de_d, de_h, de_q, err_h, err_q} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {de_d, de_h, de_q, err_h, err_q}); end
    end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (cap_d[0] !== {3{C00}}) begin errors++; $display("FAIL release_hold got=%h exp=%h", cap_d[0], {3{C00}}); end
    for (int s = 1; s < 20; s++) begin
      checks++; if (cap_d[s] !== {C00, C00, C10} || cde_d[s] !== 1'b0) begin errors++; $display("FAIL vsync_ctrl s=%0d got=%h de=%b exp=%h de=0", s, cap_d[s], cde_d[s], {C00, C00, C10}); end
    end
    checks++; if (cap_h[10][9:0] !== C00) begin errors++; $display("FAIL hdmi_flush got=%h exp=%h", cap_h[10][9:0], C00); end
    checks++; if (cap_h[11] !== {C00, C00, C10}) begin errors++; $display("FAIL hdmi_vsync got=%h exp=%h", cap_h[11], {C00, C00, C10}); end
  endtask

  task automatic test_dvi_video();
    logic [9:0] exp_seq [10] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h100};
    n = 0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (cde_d[2] !== 1'b0 || cap_d[2][9:0] !== C00) begin errors++; $display("FAIL dvi_pre_rise got=%h de=%b exp=%h de=0", cap_d[2][9:0], cde_d[2], C00); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (cap_d[3+k][9:0] !== exp_seq[k] || cap_d[3+k][29:20] !== exp_seq[k] || cde_d[3+k] !== 1'b1) begin
        errors++; $display("FAIL dvi_zero k=%0d got=%h/%h de=%b exp=%h de=1", k, cap_d[3+k][9:0], cap_d[3+k][29:20], cde_d[3+k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_hdmi_window();
    logic [29:0] e;
    n = 0;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (cap_h[30] !== {C00, C00, C01}) begin errors++; $display("FAIL hdmi_before_win got=%h exp=%h", cap_h[30], {C00, C00, C01}); end
    for (int k = 0; k < 10; k++) begin
      e = k < 8 ? {C00, C01, C01} : {G0, G1, G0};
      checks++; if (cap_h[31+k] !== e || cde_h[31+k] !== 1'b0) begin errors++; $display("FAIL hdmi_win k=%0d got=%h de=%b exp=%h de=0", k, cap_h[31+k], cde_h[31+k], e); end
      checks++; if (cap_q[31+k][39:30] !== (k < 8 ? C00 : G0)) begin errors++; $display("FAIL quad_ch3_win k=%0d got=%h exp=%h", k, cap_q[31+k][39:30], k < 8 ? C00 : G0); end
    end
    checks++; if (cde_h[41] !== 1'b1 || cap_h[41] !== {3{10'h100}}) begin errors++; $display("FAIL hdmi_first_video got=%h de=%b exp=%h de=1", cap_h[41], cde_h[41], {3{10'h100}}); end
    checks++; if (cerr_h[50] !== 1'b0) begin errors++; $display("FAIL hdmi_no_err got=%b exp=0", cerr_h[50]); end
  endtask

  task automatic test_short_blank();
    n = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int s = 11; s < 45; s++) begin
      checks++; if (cde_h[s] !== in_a[s-11]) begin errors++; $display("FAIL short_de s=%0d got=%b exp=%b", s, cde_h[s], in_a[s-11]); end
    end
    checks++; if (cerr_h[22] !== 1'b0) begin errors++; $display("FAIL short_err_early got=%b exp=0", cerr_h[22]); end
    for (int s = 23; s < 45; s++) begin
      checks++; if (cerr_h[s] !== 1'b1) begin errors++; $display("FAIL short_err_sticky s=%0d got=%b exp=1", s, cerr_h[s]); end
    end
    checks++; if (cap_h[13][19:10] !== C01 || cap_h[22][19:10] !== G1) begin errors++; $display("FAIL lineA_win got=%h,%h exp=%h,%h", cap_h[13][19:10], cap_h[22][19:10], C01, G1); end
    checks++; if (cap_h[23][9:0] !== 10'h100) begin errors++; $display("FAIL lineA_first got=%h exp=100", cap_h[23][9:0]); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (cap_h[29+k][19:10] !== (k < 3 ? C01 : G1)) begin errors++; $display("FAIL trunc_win k=%0d got=%h exp=%h", k, cap_h[29+k][19:10], k < 3 ? C01 : G1); end
    end
    checks++; if (cap_h[34][9:0] !== 10'h100 || cap_h[35][9:0] !== 10'h3FF) begin errors++; $display("FAIL lineB_video got=%h,%h exp=100,3ff", cap_h[34][9:0], cap_h[35][9:0]); end
    checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL dvi_err got=%b exp=0", err_d); end
  endtask

  task automatic test_mid_reset();
    n = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (cap_h[18] !== {3{C00}} || cap_d[18] !== {3{C00}} || cap_q[18] !== {4{C00}}) begin errors++; $display("FAIL midrst_tmds got=%h/%h exp=%h", cap_h[18], cap_d[18], {3{C00}}); end
    checks++; if ({cde_h[18], cde_d[18], cerr_h[18]} !== 3'b0) begin errors++; $display("FAIL midrst_flags got=%b exp=000", {cde_h[18], cde_d[18], cerr_h[18]}); end
    checks++; if (cap_h[19] !== {3{C00}}) begin errors++; $display("FAIL midrst_hold got=%h exp=%h", cap_h[19], {3{C00}}); end
    checks++; if (cde_h[25] !== 1'b0) begin errors++; $display("FAIL midrst_abort got=%b exp=0", cde_h[25]); end
    checks++; if (cde_d[31] !== 1'b0 || cde_d[32] !== 1'b1 || cap_d[32][9:0] !== 10'h100 || cap_d[33][9:0] !== 10'h3FF) begin errors++; $display("FAIL midrst_dvi got=%h,%h de=%b%b exp=100,3ff de=01", cap_d[32][9:0], cap_d[33][9:0], cde_d[31], cde_d[32]); end
    checks++; if (cap_h[41][9:0] !== G0 || cde_h[42] !== 1'b1 || cap_h[42][9:0] !== 10'h100) begin errors++; $display("FAIL midrst_hdmi got=%h,%h de=%b exp=%h,100 de=1", cap_h[41][9:0], cap_h[42][9:0], cde_h[42], G0); end
    checks++; if (cerr_h[52] !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", cerr_h[52]); end
  endtask

  task automatic test_quad_random();
    int cnt_m [4] = '{0, 0, 0, 0};
    int r, pos;
    logic h;
    logic [9:0] e;
    n = 0;
    for (int l = 0; l < 3; l++) begin
      h = 1'($urandom_range(0, 1));
      for (int i = 0; i < 12; i++) step(1'b0, h, 1'b0, $urandom);
      for (int i = 0; i < 8; i++) step(1'b0, h, 1'b1, $urandom);
    end
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, $urandom);
    for (int c = 0; c + 11 < n; c++) begin
      r = -1;
      for (int j = c + 1; j <= c + 10 && j < n; j++) if (r < 0 && in_a[j] && !in_a[j-1]) r = j;
      pos = r - 10 < 0 ? c : c - (r - 10);
      for (int ch = 0; ch < 4; ch++) begin
        if (in_a[c]) e = ref_enc(in_d[c][8*ch +: 8], cnt_m[ch], cnt_m[ch]);
        else begin
          cnt_m[ch] = 0;
          if (r >= 0 && pos < 8) e = ch == 0 ? tb_ctrl(in_v[c], in_h[c]) : ch == 1 ? C01 : C00;
          else if (r >= 0) e = ch == 1 ? G1 : G0;
          else e = ch == 0 ? tb_ctrl(in_v[c], in_h[c]) : C00;
        end
        checks++; if (cap_q[c+11][10*ch +: 10] !== e) begin errors++; $display("FAIL quad_ch%0d c=%0d got=%h exp=%h", ch, c, cap_q[c+11][10*ch +: 10], e); end
      end
      checks++; if (cde_q[c+11] !== in_a[c]) begin errors++; $display("FAIL quad_de c=%0d got=%b exp=%b", c, cde_q[c+11], in_a[c]); end
    end
    checks++; if (err_q !== 1'b0) begin errors++; $display("FAIL quad_err got=%b exp=0", err_q); end
  endtask

  initial begin
    test_reset();
    test_dvi_video();
    test_hdmi_window();
    test_short_blank();
    test_mid_reset();
    test_quad_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
